r_operand_fetch: RTL
====================

# r_operand_fetch

Operand-fetch stage directly upstream of the R-type ALU in the single-cycle RISC-V core, converted to a valid/ready pipelined front end. Accepts a 32-bit instruction, checks that it is a legal RV32I R-type encoding, and reads rs1 and rs2 from the integer register file. Tracks outstanding destination registers with a busy scoreboard and presents a registered `instr`/`rs1_val`/`rs2_val`/`rd` bundle to the ALU. Owns the register file and accepts the ALU result through a write-back port.

## Interface
- `XLEN`, 32: data width; fixed at 32 for RV32I
- `NREG`, 32: architectural register count; index width is 5
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: upstream instruction valid
- `in_ready` out 1: stage accepts this cycle
- `in_instr` in 32: instruction word
- `out_valid` out 1: bundle valid to ALU
- `out_ready` in 1: ALU consumes bundle
- `out_instr` out 32: instruction forwarded to ALU
- `out_rs1_val` out 32: rs1 operand
- `out_rs2_val` out 32: rs2 operand
- `out_rd` out 5: destination index
- `wb_en` in 1: write-back strobe
- `wb_rd` in 5: write-back index
- `wb_data` in 32: write-back value
- `illegal` out 1: one-cycle pulse, rejected instruction

## Operation
- **Legal** means all of the following:
  - opcode[6:0] = 0110011;
  - funct7 = 0000000, any funct3; or funct7 = 0100000 with funct3 = 000 or 101.
- **Hazard:**
  - `busy[rs1]` or `busy[rs2]` or `busy[rd]` is set, for any nonzero index.
  - Exception: a bit being cleared by a write-back in the same cycle does not count as a hazard. This exception applies only with `OPF_BYPASS_EN`.
- **Ready rule:**
  - `in_ready = (!out_valid || out_ready) && !(legal && hazard)`.
  - Illegal instructions are always consumed when the output slot is free.
- **Accept of a legal instruction:**
  - Load the output register with the instruction, rs1/rs2 values and rd.
  - Set `out_valid`.
  - Set `busy[rd]` if rd ≠ 0.
- **Accept of an illegal instruction:**
  - Drop it and leave the output register untouched.
  - Pulse `illegal` for one cycle on the next cycle.
  - Set no busy bit.
- **Output slot:** when the output is consumed and nothing new is accepted, clear `out_valid`.
- **Register file:**
  - Reads of x0 return 0.
  - A write occurs on `wb_en` at the clock edge; writes to rd = 0 are discarded.
  - `wb_en` clears `busy[wb_rd]`, including writes to registers that are not busy (used for init).
- **Simultaneous set and clear of the same busy bit:** set wins.
- **Reset:**
  - `out_valid`, `illegal` and all out_* fields go to 0.
  - All busy bits clear.
  - All registers go to 0.
  - `in_ready` then follows the ready rule above.
  - Reset mid-handshake discards the in-flight bundle.

## Timing
- Latency: instruction accepted at edge N appears on out_* after edge N, so `out_valid` is high in cycle N+1.
- Throughput: one instruction per cycle with no hazards and `out_ready` held high.
- out_* fields hold stable while `out_valid && !out_ready`.
- Dependent instruction, with bypass: accepted in the same cycle as the matching `wb_en`; its operand equals `wb_data`.
- Dependent instruction, without bypass: accepted in the cycle after the `wb_en` edge.
- `illegal`: registered, high exactly one cycle.

## Configuration
- Macro: `OPF_BYPASS_EN`.
- **Defined:**
  - Write-back data is forwarded combinationally to the rs1/rs2 reads when `wb_en && wb_rd == rs && rs != 0`.
  - Same-cycle clears are excluded from the hazard check.
- **Undefined:**
  - Reads come only from stored registers.
  - Any busy bit stalls, so there is a one-cycle extra bubble per RAW dependence.

## Structure
- Shared package `rv_pkg`:
  - `OPCODE_OP` = 7'b0110011
  - `FUNCT7_BASE` = 7'b0000000
  - `FUNCT7_ALT` = 7'b0100000
  - `XLEN`
  - a `reg_idx_t` 5-bit typedef
- Sub-module `rv_regfile`: 32×XLEN, two asynchronous read ports, one synchronous write port, x0 hardwired to zero, async active-low reset.
- Decode, scoreboard and handshake logic stay in `r_operand_fetch`.

## Test plan
1. **Basic issue:** reset; write-back x5 = 7 and x6 = 3; issue 0x006283B3 (add x7,x5,x6) → next cycle `out_valid` = 1, `rs1_val` = 7, `rs2_val` = 3, `out_rd` = 7, `busy[7]` = 1.
2. **RAW dependence:** immediately offer 0x40538433 (sub x8,x7,x5) → `in_ready` = 0.
   - Drive `wb_en`, `wb_rd` = 7, `wb_data` = 10.
   - With bypass: accepted that cycle with `rs1_val` = 10.
   - Without bypass: accepted one cycle later with `rs1_val` = 10.
3. **Backpressure:** hold `out_ready` = 0 for 3 cycles with a second instruction pending → out_* unchanged, `in_ready` = 0, second instruction emitted after release with no loss or duplication.
4. **Illegal instruction:** offer 0x00000013 (addi) → consumed, `illegal` high exactly one cycle, `out_valid` unchanged, no busy bit set.
5. **x0 handling:** write-back rd = 0 with 0xFFFFFFFF, then issue 0x00000033 → `rs1_val` = `rs2_val` = 0, no stall, no busy bit set.
6. **Reset mid-operation:** deassert `rst_n` while `out_valid` = 1 and `busy[7]` = 1 → `out_valid` and `busy` are 0 immediately without a clock edge; after release, x5 reads 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the R-type operand-fetch stage and its register file.
// Optional write-back forwarding is selected with the OPF_BYPASS_EN macro.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef logic [4:0] reg_idx_t;

  // Only SUB and SRA use the alternate funct7 encoding.
  function automatic logic is_legal_r(input logic [31:0] instr);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f_ok;
    opc = instr[6:0];
    f3  = instr[14:12];
    f7  = instr[31:25];
    case (f7)
      FUNCT7_BASE: f_ok = 1'b1;
      FUNCT7_ALT:  f_ok = (f3 == 3'b000) || (f3 == 3'b101);
      default:     f_ok = 1'b0;
    endcase
    return (opc == OPCODE_OP) && f_ok;
  endfunction

endpackage

// File: rtl/r_operand_fetch_if.sv
// Handshake, ALU bundle and write-back signals of the operand-fetch stage.
// slave is the stage's view, master is the surrounding pipeline's view.
interface r_operand_fetch_if;
  import rv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  reg_idx_t        out_rd;
  logic            wb_en;
  reg_idx_t        wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_instr, out_rs1_val, out_rs2_val, out_rd, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_instr, out_rs1_val, out_rs2_val, out_rd, illegal
  );

endinterface

// File: rtl/rv_regfile.sv
// 32 x XLEN integer register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero.
module rv_regfile
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  reg_idx_t        waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  reg_idx_t        raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  reg_idx_t        raddr2_i,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents; writes to x0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != 5'd0)) begin
      regs_d[waddr_i] = wdata_i;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports.
  always_comb begin
    if (raddr1_i == 5'd0) begin
      rdata1_o = {XLEN{1'b0}};
    end else begin
      rdata1_o = regs_q[raddr1_i];
    end
    if (raddr2_i == 5'd0) begin
      rdata2_o = {XLEN{1'b0}};
    end else begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/r_operand_fetch.sv
// Operand-fetch stage for the R-type ALU: legality decode, busy scoreboard,
// valid/ready output slot and register file ownership. OPF_BYPASS_EN enables forwarding.
module r_operand_fetch
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  r_operand_fetch_if.slave  bus
);

  reg_idx_t        rs1_s;
  reg_idx_t        rs2_s;
  reg_idx_t        rd_s;
  logic            legal_s;
  logic            hazard_s;
  logic            in_ready_s;
  logic            accept_s;
  logic [NREG-1:0] busy_clr_s;
  logic [NREG-1:0] busy_set_s;
  logic [NREG-1:0] busy_eff_s;
  logic [XLEN-1:0] rf_rd1_s;
  logic [XLEN-1:0] rf_rd2_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

  logic [NREG-1:0] busy_q,      busy_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_rs1_q,   out_rs1_d;
  logic [XLEN-1:0] out_rs2_q,   out_rs2_d;
  reg_idx_t        out_rd_q,    out_rd_d;
  logic            illegal_q,   illegal_d;

  assign rs1_s   = bus.in_instr[19:15];
  assign rs2_s   = bus.in_instr[24:20];
  assign rd_s    = bus.in_instr[11:7];
  assign legal_s = is_legal_r(bus.in_instr);

  rv_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_rd),
    .wdata_i  (bus.wb_data),
    .raddr1_i (rs1_s),
    .rdata1_o (rf_rd1_s),
    .raddr2_i (rs2_s),
    .rdata2_o (rf_rd2_s)
  );

  // Operand selection and busy bits that still count as hazards this cycle.
  always_comb begin
`ifdef OPF_BYPASS_EN
    if (bus.wb_en && (bus.wb_rd == rs1_s) && (rs1_s != 5'd0)) begin
      rs1_val_s = bus.wb_data;
    end else begin
      rs1_val_s = rf_rd1_s;
    end
    if (bus.wb_en && (bus.wb_rd == rs2_s) && (rs2_s != 5'd0)) begin
      rs2_val_s = bus.wb_data;
    end else begin
      rs2_val_s = rf_rd2_s;
    end
    busy_eff_s = busy_q & ~busy_clr_s;
`else
    rs1_val_s  = rf_rd1_s;
    rs2_val_s  = rf_rd2_s;
    busy_eff_s = busy_q;
`endif
  end

  // Hazard detection, handshake and scoreboard set/clear vectors.
  always_comb begin
    busy_clr_s = {NREG{1'b0}};
    if (bus.wb_en) begin
      busy_clr_s[bus.wb_rd] = 1'b1;
    end else begin
      busy_clr_s = {NREG{1'b0}};
    end
    hazard_s = ((rs1_s != 5'd0) && busy_eff_s[rs1_s]) ||
               ((rs2_s != 5'd0) && busy_eff_s[rs2_s]) ||
               ((rd_s  != 5'd0) && busy_eff_s[rd_s]);
    in_ready_s = (!out_valid_q || bus.out_ready) && !(legal_s && hazard_s);
    accept_s   = bus.in_valid && in_ready_s;
    busy_set_s = {NREG{1'b0}};
    if (accept_s && legal_s && (rd_s != 5'd0)) begin
      busy_set_s[rd_s] = 1'b1;
    end else begin
      busy_set_s = {NREG{1'b0}};
    end
  end

  // Next state: a set wins over a same-cycle clear; bit 0 never becomes busy.
  always_comb begin
    busy_d      = (busy_q & ~busy_clr_s) | busy_set_s;
    busy_d[0]   = 1'b0;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_d    = out_rd_q;
    if (accept_s && legal_s) begin
      out_valid_d = 1'b1;
      out_instr_d = bus.in_instr;
      out_rs1_d   = rs1_val_s;
      out_rs2_d   = rs2_val_s;
      out_rd_d    = rd_s;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    illegal_d = accept_s && !legal_s;
  end

  // Stage state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= {NREG{1'b0}};
      out_valid_q <= 1'b0;
      out_instr_q <= {XLEN{1'b0}};
      out_rs1_q   <= {XLEN{1'b0}};
      out_rs2_q   <= {XLEN{1'b0}};
      out_rd_q    <= 5'd0;
      illegal_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_rs1_val = out_rs1_q;
  assign bus.out_rs2_val = out_rs2_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.illegal     = illegal_q;

endmodule
